// File: rtl/binary_bbox_detect_pkg.sv
// Shared definitions for the binarized-stream consumers: FSM encodings and
// the default frame geometry used by the binarization, bbox and overlay blocks.
package binary_bbox_detect_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACCUM      = 2'd1,
    PUBLISH    = 2'd2
  } bbox_state_e;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

endpackage

// File: rtl/binary_bbox_detect_sync_edge_det.sv
// Registers vsync/de once and derives the vsync rise and de fall pulses from
// the registered copies; shared by the video-stream consumers.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  input  logic de_i,
  output logic vsync_rise_o,
  output logic de_o,
  output logic de_fall_o
);

  logic vsync_q, vsync_prev_q, de_q, de_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      de_q         <= 1'b0;
      de_prev_q    <= 1'b0;
    end else begin
      vsync_q      <= vsync_i;
      vsync_prev_q <= vsync_q;
      de_q         <= de_i;
      de_prev_q    <= de_q;
    end
  end

  assign vsync_rise_o = vsync_q & ~vsync_prev_q;
  assign de_o         = de_q;
  assign de_fall_o    = ~de_q & de_prev_q;

endmodule

// File: rtl/binary_bbox_detect.sv
// Per-frame bounding box and white-pixel count of a 1-bit video stream,
// published once per frame with a one-cycle box_valid pulse.
module binary_bbox_detect
  import binary_bbox_detect_pkg::*;
#(
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter int MIN_PIXELS = 64,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int CW         = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vsync,
  input  logic          in_hsync,
  input  logic          in_de,
  input  logic          in_monoc,
  output logic [XW-1:0] box_left,
  output logic [XW-1:0] box_right,
  output logic [YW-1:0] box_top,
  output logic [YW-1:0] box_bottom,
  output logic [CW-1:0] pix_count,
  output logic          box_found,
  output logic          box_valid
);

  localparam logic [XW-1:0] X_LIM = XW'(H_RES);
  localparam logic [YW-1:0] Y_LIM = YW'(V_RES);
  localparam logic [CW-1:0] C_MIN = CW'(MIN_PIXELS);

  bbox_state_e state_q, state_d;
  logic vsync_rise, de_q, de_fall, monoc_q;
  logic [XW-1:0] x_cnt_q, x_cnt_d, min_x_q, min_x_d, max_x_q, max_x_d, min_x_b, max_x_b;
  logic [YW-1:0] y_cnt_q, y_cnt_d, min_y_q, min_y_d, max_y_q, max_y_d, min_y_b, max_y_b;
  logic [CW-1:0] cnt_q, cnt_d, cnt_b;
  logic [XW-1:0] left_q, left_d, right_q, right_d;
  logic [YW-1:0] top_q, top_d, bottom_q, bottom_d;
  logic [CW-1:0] count_q, count_d;
  logic          found_q, found_d;
  logic          publish, clr, acc, pix_hit, found_pub;
  logic          unused_hsync;

  assign unused_hsync = in_hsync;

  sync_edge_det u_sync (
    .clk          (clk),
    .rst          (rst),
    .vsync_i      (in_vsync),
    .de_i         (in_de),
    .vsync_rise_o (vsync_rise),
    .de_o         (de_q),
    .de_fall_o    (de_fall)
  );

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    clr     = 1'b0;
    acc     = 1'b0;
    case (state_q)
      WAIT_FRAME: if (vsync_rise) begin state_d = ACCUM; clr = 1'b1; end
      // the pixel arriving with the vsync rise belongs to neither frame
      ACCUM:      if (vsync_rise) begin state_d = PUBLISH; publish = 1'b1; end
                  else acc = 1'b1;
      PUBLISH:    begin state_d = ACCUM; clr = 1'b1; acc = 1'b1; end
      default:    state_d = WAIT_FRAME;
    endcase
  end

  always_comb begin
    x_cnt_d = x_cnt_q;
    if (de_fall) x_cnt_d = '0;
    else if (de_q && x_cnt_q != X_LIM) x_cnt_d = x_cnt_q + XW'(1);
    y_cnt_d = y_cnt_q;
    if (vsync_rise) y_cnt_d = '0;
    else if (de_fall && y_cnt_q != Y_LIM) y_cnt_d = y_cnt_q + YW'(1);
  end

  assign pix_hit = de_q & monoc_q & (x_cnt_q < X_LIM) & (y_cnt_q < Y_LIM);

  always_comb begin
    min_x_b = clr ? '1 : min_x_q;
    max_x_b = clr ? '0 : max_x_q;
    min_y_b = clr ? '1 : min_y_q;
    max_y_b = clr ? '0 : max_y_q;
    cnt_b   = clr ? '0 : cnt_q;
    min_x_d = min_x_b;
    max_x_d = max_x_b;
    min_y_d = min_y_b;
    max_y_d = max_y_b;
    cnt_d   = cnt_b;
    if (acc && pix_hit) begin
      if (x_cnt_q < min_x_b) min_x_d = x_cnt_q;
      if (x_cnt_q > max_x_b) max_x_d = x_cnt_q;
      if (y_cnt_q < min_y_b) min_y_d = y_cnt_q;
      if (y_cnt_q > max_y_b) max_y_d = y_cnt_q;
      if (!(&cnt_b)) cnt_d = cnt_b + CW'(1);
    end
  end

  assign found_pub = (cnt_q >= C_MIN);

  always_comb begin
    left_d   = left_q;
    right_d  = right_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    count_d  = count_q;
    found_d  = found_q;
    if (publish) begin
      left_d   = found_pub ? min_x_q : '0;
      right_d  = found_pub ? max_x_q : '0;
      top_d    = found_pub ? min_y_q : '0;
      bottom_d = found_pub ? max_y_q : '0;
      count_d  = cnt_q;
      found_d  = found_pub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_FRAME;
      monoc_q  <= 1'b0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      min_x_q  <= '1;
      max_x_q  <= '0;
      min_y_q  <= '1;
      max_y_q  <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
      count_q  <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      monoc_q  <= in_monoc;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      count_q  <= count_d;
      found_q  <= found_d;
    end
  end

  assign box_left   = left_q;
  assign box_right  = right_q;
  assign box_top    = top_q;
  assign box_bottom = bottom_q;
  assign pix_count  = count_q;
  assign box_found  = found_q;
  assign box_valid  = (state_q == PUBLISH);

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Directed bench for binary_bbox_detect: a table of 16x8 frames with expected
// boxes, plus hand sequences for reset, vsync-edge pixels and latency.
module tb_binary_bbox_detect;

  logic clk = 1'b0;
  logic rst, in_vsync, in_hsync, in_de, in_monoc;
  logic [9:0]  l1, r1, l4, r4;
  logic [8:0]  t1, b1, t4, b4;
  logic [18:0] c1, c4;
  logic        f1, f4, bv1, bv4;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt1 = 0;
  int vcnt4 = 0;

  always #5 clk = ~clk;

  binary_bbox_detect #(.H_RES(16), .V_RES(8), .MIN_PIXELS(1), .XW(10), .YW(9), .CW(19)) dut1 (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_monoc(in_monoc), .box_left(l1), .box_right(r1), .box_top(t1), .box_bottom(b1),
    .pix_count(c1), .box_found(f1), .box_valid(bv1));

  binary_bbox_detect #(.H_RES(16), .V_RES(8), .MIN_PIXELS(4), .XW(10), .YW(9), .CW(19)) dut4 (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_monoc(in_monoc), .box_left(l4), .box_right(r4), .box_top(t4), .box_bottom(b4),
    .pix_count(c4), .box_found(f4), .box_valid(bv4));

  always @(negedge clk) begin
    if (bv1) vcnt1++;
    if (bv4) vcnt4++;
  end

  typedef struct {
    logic [127:0] bm;
    int           width;
    int           lines;
    bit           use4;
    int           l, r, t, b, c;
    bit           f;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_frame(input logic [127:0] bm, input int w, input int nl);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < w; x++) begin
        in_de    = 1'b1;
        in_monoc = (x < 16 && y < 8) ? bm[y*16+x] : 1'b1;
        step();
      end
      in_de = 1'b0; in_monoc = 1'b0; in_hsync = 1'b1;
      step();
      in_hsync = 1'b0;
      step();
    end
  endtask

  task automatic vsync_only();
    in_vsync = 1'b1;
    repeat (3) step();
    in_vsync = 1'b0;
    repeat (2) step();
  endtask

  task automatic publish(input bit use4, input int el, input int er, input int et,
                         input int eb, input int ec, input bit ef,
                         input bit rise_px, input bit pub_px, input string tag);
    in_vsync = 1'b1;
    if (rise_px) begin in_de = 1'b1; in_monoc = 1'b1; end
    step();
    in_de = 1'b0; in_monoc = 1'b0;
    chk({tag, "_lat1"}, 32'(use4 ? bv4 : bv1), 32'd0);
    if (pub_px) begin in_de = 1'b1; in_monoc = 1'b1; end
    step();
    in_de = 1'b0; in_monoc = 1'b0;
    chk({tag, "_valid"},  32'(use4 ? bv4 : bv1), 32'd1);
    chk({tag, "_left"},   32'(use4 ? l4 : l1), el);
    chk({tag, "_right"},  32'(use4 ? r4 : r1), er);
    chk({tag, "_top"},    32'(use4 ? t4 : t1), et);
    chk({tag, "_bottom"}, 32'(use4 ? b4 : b1), eb);
    chk({tag, "_count"},  32'(use4 ? c4 : c1), ec);
    chk({tag, "_found"},  32'(use4 ? f4 : f1), 32'(ef));
    step();
    chk({tag, "_pulse"},  32'(use4 ? bv4 : bv1), 32'd0);
    chk({tag, "_hold"},   32'(use4 ? c4 : c1), ec);
    in_vsync = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int v0;
    vecs[0] = '{bm:(128'd1 << 21), width:16, lines:8, use4:1'b0, l:5, r:5, t:1, b:1, c:1, f:1'b1};
    vecs[1] = '{bm:(128'd1 << 35) | (128'd1 << 90), width:16, lines:8, use4:1'b0,
                l:3, r:10, t:2, b:5, c:2, f:1'b1};
    vecs[2] = '{bm:128'd0, width:16, lines:8, use4:1'b0, l:0, r:0, t:0, b:0, c:0, f:1'b0};
    vecs[3] = '{bm:(128'd1 << 17) | (128'd1 << 34) | (128'd1 << 51), width:16, lines:8,
                use4:1'b1, l:0, r:0, t:0, b:0, c:3, f:1'b0};
    vecs[4] = '{bm:(128'd1 << 17) | (128'd1 << 34) | (128'd1 << 51) | (128'd1 << 68),
                width:16, lines:8, use4:1'b1, l:1, r:4, t:1, b:4, c:4, f:1'b1};
    vecs[5] = '{bm:~128'd0, width:20, lines:10, use4:1'b0, l:0, r:15, t:0, b:7, c:128, f:1'b1};
    vecs[6] = '{bm:(128'd1 << 0) | (128'd1 << 127), width:16, lines:8, use4:1'b0,
                l:0, r:15, t:0, b:7, c:2, f:1'b1};

    rst = 1'b1; in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_monoc = 1'b0;
    repeat (3) step();
    chk("rst_left",   32'(l1), 0);
    chk("rst_right",  32'(r1), 0);
    chk("rst_top",    32'(t1), 0);
    chk("rst_bottom", 32'(b1), 0);
    chk("rst_count",  32'(c1), 0);
    chk("rst_found",  32'(f1), 0);
    chk("rst_valid",  32'(bv1), 0);

    // reset released mid-frame: partial frame and first vsync produce nothing
    rst = 1'b0;
    drive_frame(~128'd0, 16, 4);
    vsync_only();
    chk("t1_no_valid1", vcnt1, 0);
    chk("t1_no_valid4", vcnt4, 0);

    for (int i = 0; i < 7; i++) begin
      drive_frame(vecs[i].bm, vecs[i].width, vecs[i].lines);
      publish(vecs[i].use4, vecs[i].l, vecs[i].r, vecs[i].t, vecs[i].b, vecs[i].c, vecs[i].f,
              1'b0, 1'b0, $sformatf("v%0d", i));
    end

    // pixel on the vsync-rise cycle is counted in neither frame
    drive_frame(128'd1 << 50, 16, 8);
    publish(1'b0, 2, 2, 3, 3, 1, 1'b1, 1'b1, 1'b0, "rise_old");
    drive_frame(128'd0, 16, 8);
    publish(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, "rise_new");
    // pixel during PUBLISH lands in the new frame at (0,0)
    drive_frame(128'd0, 16, 8);
    publish(1'b0, 0, 0, 0, 0, 1, 1'b1, 1'b0, 1'b0, "pub_px");

    // reset mid-frame drops the frame and waits for a fresh vsync
    drive_frame(~128'd0, 16, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_left",  32'(l1), 0);
    chk("mrst_count", 32'(c1), 0);
    chk("mrst_found", 32'(f1), 0);
    chk("mrst_valid", 32'(bv1), 0);
    v0 = vcnt1;
    drive_frame(~128'd0, 16, 2);
    vsync_only();
    chk("mrst_no_valid", vcnt1 - v0, 0);
    drive_frame(128'd1 << 38, 16, 8);
    publish(1'b0, 6, 6, 2, 2, 1, 1'b1, 1'b0, 1'b0, "mrst_next");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
